// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: arbiter state encoding and round-robin pointer helper.
package fifo_arb_pkg;

    typedef enum logic [1:0] {IDLE, ARB, BURST} arb_state_t;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, lowest valid index at or after ptr.
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [2*N_REQ-1:0] masked;
    logic               hit;

    // Upper copy keeps every request, so the wrap-around case is found past the masked lower copy.
    assign masked = {req, req} & ({2*N_REQ{1'b1}} << ptr);

    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int i = 0; i < 2*N_REQ; i++) begin
            if (masked[i] && !hit) begin
                idx = IW'(i % N_REQ);
                hit = 1'b1;
            end
        end
    end

    assign any = |req;
    assign gnt = any ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO push port among N_REQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ-1:0]         req_last_i,
    input  logic [N_REQ*WIDTH-1:0]   req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic                     fifo_ready_i,
    output logic                     fifo_valid_o,
    output logic [WIDTH-1:0]         fifo_data_o,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] grant_id_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t       state, state_n;
    logic [IW-1:0]    rr_ptr, pick_idx;
    logic [CW-1:0]    beat_cnt;
    logic [N_REQ-1:0] pick_gnt;
    logic             pick_any, in_burst, xfer, rel;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req (req_valid_i),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign in_burst = state == BURST;
    assign xfer     = in_burst && req_valid_i[grant_id_o] && fifo_ready_i;
    assign rel      = xfer && (req_last_i[grant_id_o] || beat_cnt == CW'(MAX_BURST - 1));

    always_comb begin
        state_n = (state == IDLE) ? (|req_valid_i ? ARB : IDLE)
                : (state == ARB)  ? (pick_any ? BURST : IDLE)
                : rel             ? (|req_valid_i ? ARB : IDLE)
                : BURST;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            grant_o    <= '0;
            grant_id_o <= '0;
        end else begin
            state <= state_n;
            if (state == ARB) begin
                grant_o    <= pick_gnt;
                grant_id_o <= pick_any ? pick_idx : grant_id_o;
                beat_cnt   <= '0;
            end
            if (xfer)
                beat_cnt <= beat_cnt + CW'(1);
            if (rel) begin
                rr_ptr  <= IW'(rr_next(32'(grant_id_o), N_REQ));
                grant_o <= '0;
            end
        end
    end

    // Data path is a pure mux off the registered grant: no added latency.
    assign req_ready_o  = in_burst ? (N_REQ'(fifo_ready_i) << grant_id_o) : '0;
    assign fifo_valid_o = in_burst && req_valid_i[grant_id_o];
    assign fifo_data_o  = in_burst ? req_data_i[grant_id_o*WIDTH +: WIDTH] : '0;

endmodule
